p2s_tx: RTL



---
 rtl/p2s_tx.sv | 72 +++++++
 1 files changed

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: sends SYNC_BYTES sync symbols after reset,
// then one byte every 8 bit-clocks, MSB first, filling empty slots with idle.
module p2s_tx #(
    parameter logic [7:0]  COM_SYM    = 8'hBC,
    parameter logic [7:0]  IDL_SYM    = 8'h7C,
    parameter int unsigned SYNC_BYTES = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic [7:0] data_32_8,
    input  logic       valid_32_8,
    output logic       ready_p2s,
    output logic       data_out,
    output logic       byte_start,
    output logic       link_active
);

    typedef enum logic {
        SYNC,
        ACTIVE
    } state_t;

    localparam logic [3:0] SC_LAST = 4'(SYNC_BYTES - 1);

    logic [7:0] sh_q, sh_d;
    logic [2:0] bc_q, bc_d;
    logic [3:0] sc_q, sc_d;
    state_t     state_q, state_d;
    logic       load;

    // bc==7 marks the last bit of a byte, so the following edge reloads sh
    assign load = (bc_q == 3'd7);

    always_comb begin
        sh_d    = {sh_q[6:0], 1'b0};
        bc_d    = bc_q + 3'd1;
        sc_d    = sc_q;
        state_d = state_q;
        if (load) begin
            if (state_q == SYNC) begin
                sh_d = COM_SYM;
                if (sc_q == SC_LAST) begin
                    state_d = ACTIVE;
                end else begin
                    sc_d = sc_q + 4'd1;
                end
            end else begin
                sh_d = valid_32_8 ? data_32_8 : IDL_SYM;
            end
        end
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sh_q    <= 8'h00;
            bc_q    <= 3'd7;
            sc_q    <= 4'd0;
            state_q <= SYNC;
        end else begin
            sh_q    <= sh_d;
            bc_q    <= bc_d;
            sc_q    <= sc_d;
            state_q <= state_d;
        end
    end

    assign data_out    = sh_q[7];
    assign byte_start  = (bc_q == 3'd0);
    assign link_active = (state_q == ACTIVE);
    assign ready_p2s   = (state_q == ACTIVE) && load;

endmodule
